seg_scan_driver: RTL
====================

Name: seg_scan_driver

Overview:
Time-multiplexed driver for an N-digit common-anode 7-segment display with hex decode, per-digit decimal point and blanking. Accepts a display word through a valid/ready load handshake. New words are applied only at frame boundaries, so a frame never mixes old and new digits. Scans one digit at a time, with a dead interval between digits to suppress ghosting. Sits between the application datapath and the board segment/anode pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (1..16)
CLK_DIV, 50000, clk cycles each digit is lit (>=1)
DEAD_CYCLES, 16, clk cycles all anodes are off between digits (0 = no dead phase)
SEG_ACTIVE_LOW, 1, 1: seg/dp low = lit; 0: inverted
AN_ACTIVE_LOW, 1, 1: an low = digit enabled; 0: inverted

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
load_valid  in  1  new display word offered
load_ready  out  1  block can accept a word
value_in  in  4*NUM_DIGITS  hex nibbles; nibble i drives digit i (digit 0 = LSB nibble)
dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit
blank_in  in  NUM_DIGITS  1 = digit dark
seg  out  7  segments {g,f,e,d,c,b,a}, registered
dp  out  1  decimal point, registered
an  out  NUM_DIGITS  anode enables, one-hot when active, registered
frame_tick  out  1  one-cycle pulse at each frame start

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - an all inactive; seg and dp off (polarity per parameters); frame_tick 0; load_ready 1.
  - Active and pending registers: value 0, dp 0, blank all-ones, so the display is dark until the first load.
  - FSM in SHOW, digit index 0, cycle counter 0.
- Handshake:
  - A word is accepted on a clk edge where load_valid && load_ready; it is captured into the pending registers.
  - load_ready drops the next cycle and stays low until the frame boundary.
  - load_valid while ready is low is ignored. The producer must hold its inputs.
- FSM:
  - SHOW: the an bit for the current index is active; seg/dp come from the active registers.
  - SHOW lasts CLK_DIV cycles, then goes to DEAD. If DEAD_CYCLES=0 it goes straight to the next digit's SHOW.
  - DEAD: all an inactive, seg and dp off. Lasts DEAD_CYCLES cycles, then the index advances.
- Index: increments modulo NUM_DIGITS.
- Frame boundary: the transition into SHOW of digit 0 after the last digit. On that edge:
  - If a word is pending, pending is copied to active and load_ready returns to 1.
  - frame_tick pulses for that single cycle, whether or not a word was pending.
- Accept at the boundary edge: if a word is accepted on the same edge as a boundary, it waits for the next boundary (pending capture wins; no same-cycle bypass).
- Latency: outputs for index i appear on the edge the FSM enters SHOW(i).
  - Frame length = NUM_DIGITS*(CLK_DIV+DEAD_CYCLES) cycles.
  - A word accepted at cycle t is visible no later than t + one frame length + 1.
- Blanked digit: its anode is still enabled during its slot (uniform duty), but seg and dp are off.
- Decode (active-low raw, before SEG_ACTIVE_LOW):
  - 0 1000000, 1 1111001, 2 0100100, 3 0110000
  - 4 0011001, 5 0010010, 6 0000010, 7 1111000
  - 8 0000000, 9 0010000, A 0001000, b 0000011
  - C 1000110, d 0100001, E 0000110, F 0001110
- Counter width: $clog2(max(CLK_DIV,DEAD_CYCLES,2)). The counter wraps to 0 on every phase change.
- Reset mid-frame: asynchronously returns all outputs and state to reset values. Any pending word is discarded.

Optional Feature:
LEADING_ZERO_BLANK_EN.
- Defined: at the frame boundary, the active blank mask is ORed with a leading-zero mask. Digits from NUM_DIGITS-1 downward whose nibble is 0 are blanked, stopping at the first nonzero nibble. Digit 0 is never auto-blanked.
- Undefined: only blank_in controls blanking.

Decomposition:
- Package seg_pkg holds:
  - the 16-entry decode table as a localparam array;
  - the SEG_OFF constant;
  - the FSM state typedef (SHOW, DEAD).
- Sub-module hex_seg_decode: a combinational nibble-to-raw-segment decoder, instantiated once on the muxed nibble.

Test Plan:
Bench configuration: NUM_DIGITS=4, CLK_DIV=4, DEAD_CYCLES=2, frame = 24 cycles.
1. Reset, then 30 cycles idle -> an=1111 during DEAD and 1110/1101/... during SHOW; seg=1111111 throughout; load_ready=1; frame_tick every 24 cycles.
2. Load value_in=16'h12AF, dp_in=0, blank_in=0 -> load_ready low until the next frame_tick. Next frame shows: an=1110 seg=0001110; 1101 0001000; 1011 0100100; 0111 1111001.
3. Load 16'h0000, then 16'h8888 held during load_ready=0 -> second word is not accepted until ready returns; the 0000 frame is fully displayed before 8888 appears.
4. dp_in=4'b0100, blank_in=4'b0001, value 16'h3210 -> digit 2 has dp=0; digit 0 has seg=1111111 and dp=1 with its anode still active.
5. Assert rst mid-SHOW of digit 2 -> same-cycle an=1111, seg=1111111, load_ready=1. After release, the display stays dark until a new load.
6. With LEADING_ZERO_BLANK_EN defined, load 16'h0050 -> digits 3 and 2 dark; digit 1 shows 0010010; digit 0 shows 1000000.

Source files
------------

// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the 7-segment scan driver:
//   SEG_TABLE : hex nibble -> raw segments {g,f,e,d,c,b,a}, active-low
//   SEG_OFF   : raw (active-low) pattern with every segment dark
//   state_t   : scan FSM states (SHOW = digit lit, DEAD = all anodes off)
// -----------------------------------------------------------------------------
package seg_pkg;

   typedef enum logic {
      SHOW = 1'b0,
      DEAD = 1'b1
   } state_t;

   localparam logic [6:0] SEG_OFF = 7'b1111111;

   localparam logic [6:0] SEG_TABLE [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

endpackage

// File: rtl/hex_seg_decode.sv
// -----------------------------------------------------------------------------
// hex_seg_decode
// Combinational hex nibble to raw 7-segment decoder (active-low raw form).
// Ports:
//   i_nibble  [3:0]  hex digit to decode
//   o_seg_raw [6:0]  segments {g,f,e,d,c,b,a}, 0 = lit
// -----------------------------------------------------------------------------
module hex_seg_decode
   import seg_pkg::*;
(
   input  logic [3:0] i_nibble,
   output logic [6:0] o_seg_raw
);

   assign o_seg_raw = SEG_TABLE[i_nibble];

endmodule

// File: rtl/seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seg_scan_driver
// Time-multiplexed driver for an N-digit common-anode 7-segment display.
// A display word is taken over a valid/ready handshake into a pending buffer
// and copied to the active buffer only at a frame boundary, so a frame never
// mixes digits from two words. Each digit is lit for CLK_DIV cycles followed
// by DEAD_CYCLES cycles with every anode off.
//
// Ports:
//   clk         system clock
//   rst         asynchronous, active-high reset
//   load_valid  producer offers a display word
//   load_ready  driver can accept a word (low from accept to frame boundary)
//   value_in    hex nibbles, nibble i drives digit i
//   dp_in       decimal point per digit, 1 = lit
//   blank_in    per-digit blank, 1 = dark
//   seg         registered segments {g,f,e,d,c,b,a}
//   dp          registered decimal point
//   an          registered anode enables, one-hot when a digit is shown
//   frame_tick  one-cycle pulse at each frame start
//
// Optional build macro: LEADING_ZERO_BLANK_EN -- when defined, leading zero
// digits (never digit 0) are blanked as the word becomes active.
// -----------------------------------------------------------------------------
module seg_scan_driver
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS     = 4,
   parameter int CLK_DIV        = 50000,
   parameter int DEAD_CYCLES    = 16,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int AN_ACTIVE_LOW  = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load_valid,
   output logic                    load_ready,
   input  logic [4*NUM_DIGITS-1:0] value_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   blank_in,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_tick
);

   localparam int CNT_MAX0 = (CLK_DIV > DEAD_CYCLES) ? CLK_DIV : DEAD_CYCLES;
   localparam int CNT_MAX  = (CNT_MAX0 > 2) ? CNT_MAX0 : 2;
   localparam int CW       = $clog2(CNT_MAX);
   localparam int IW       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [CW-1:0] SHOW_LAST = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] DEAD_LAST = CW'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);
   localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

   // Physical "off" levels after polarity selection
   localparam logic [NUM_DIGITS-1:0] AN_OFF      = {NUM_DIGITS{AN_ACTIVE_LOW != 0}};
   localparam logic [6:0]            SEG_OFF_PHY = (SEG_ACTIVE_LOW != 0) ? SEG_OFF : ~SEG_OFF;
   localparam logic                  DP_OFF_PHY  = (SEG_ACTIVE_LOW != 0);

   state_t                  r_state, w_state_nxt;
   logic [IW-1:0]           r_idx, w_idx_nxt;
   logic [CW-1:0]           r_cnt, w_cnt_nxt;
   logic [4*NUM_DIGITS-1:0] r_act_val, w_act_val_nxt, r_pend_val, w_pend_val_nxt;
   logic [NUM_DIGITS-1:0]   r_act_dp, w_act_dp_nxt, r_pend_dp, w_pend_dp_nxt;
   logic [NUM_DIGITS-1:0]   r_act_blank, w_act_blank_nxt, r_pend_blank, w_pend_blank_nxt;
   logic                    r_ready, w_ready_nxt;
   logic                    w_advance, w_boundary;
   logic [NUM_DIGITS-1:0]   w_lz_mask;
   logic [3:0]              w_nibble;
   logic [6:0]              w_seg_dec;
   logic [NUM_DIGITS-1:0]   w_an_low;
   logic [6:0]              w_seg_low;
   logic                    w_dp_low;
   logic [NUM_DIGITS-1:0]   r_an;
   logic [6:0]              r_seg;
   logic                    r_dp, r_tick;

`ifdef LEADING_ZERO_BLANK_EN
   // Blank zero nibbles from the top digit down, stopping at the first
   // nonzero one; digit 0 is never considered.
   function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [4*NUM_DIGITS-1:0] val);
      logic [NUM_DIGITS-1:0] m;
      logic                  run;
      m   = '0;
      run = 1'b1;
      for (int unsigned i = NUM_DIGITS - 1; i >= 1; i--) begin
         if (run && (val[4*i +: 4] == 4'h0)) m[i] = 1'b1;
         else                               run  = 1'b0;
      end
      return m;
   endfunction
   assign w_lz_mask = lz_mask(r_pend_val);
`else
   assign w_lz_mask = '0;
`endif

   // Next-state: scan sequencing plus load/commit handshake
   always_comb begin
      w_state_nxt      = r_state;
      w_idx_nxt        = r_idx;
      w_cnt_nxt        = r_cnt + 1'b1;
      w_advance        = 1'b0;
      w_boundary       = 1'b0;
      w_act_val_nxt    = r_act_val;
      w_act_dp_nxt     = r_act_dp;
      w_act_blank_nxt  = r_act_blank;
      w_pend_val_nxt   = r_pend_val;
      w_pend_dp_nxt    = r_pend_dp;
      w_pend_blank_nxt = r_pend_blank;
      w_ready_nxt      = r_ready;

      case (r_state)
         SHOW: if (r_cnt == SHOW_LAST) begin
            w_cnt_nxt = '0;
            if (DEAD_CYCLES == 0) w_advance   = 1'b1;
            else                  w_state_nxt = DEAD;
         end
         DEAD: if (r_cnt == DEAD_LAST) begin
            w_cnt_nxt   = '0;
            w_state_nxt = SHOW;
            w_advance   = 1'b1;
         end
         default: w_state_nxt = SHOW;
      endcase

      if (w_advance) begin
         w_boundary = (r_idx == IDX_LAST);
         w_idx_nxt  = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end

      // ready low means a word is pending, so commit and accept never coincide;
      // a word accepted on a boundary edge waits for the following boundary.
      if (w_boundary && !r_ready) begin
         w_act_val_nxt   = r_pend_val;
         w_act_dp_nxt    = r_pend_dp;
         w_act_blank_nxt = r_pend_blank | w_lz_mask;
         w_ready_nxt     = 1'b1;
      end else if (load_valid && r_ready) begin
         w_pend_val_nxt   = value_in;
         w_pend_dp_nxt    = dp_in;
         w_pend_blank_nxt = blank_in;
         w_ready_nxt      = 1'b0;
      end
   end

   // Outputs are registered from the next state so digit i appears on the
   // very edge that enters SHOW(i), using the freshly committed word.
   assign w_nibble = w_act_val_nxt[{w_idx_nxt, 2'b00} +: 4];

   hex_seg_decode u_dec (
      .i_nibble  (w_nibble),
      .o_seg_raw (w_seg_dec)
   );

   always_comb begin
      w_an_low  = '1;
      w_seg_low = SEG_OFF;
      w_dp_low  = 1'b1;
      if (w_state_nxt == SHOW) begin
         w_an_low[w_idx_nxt] = 1'b0;
         if (!w_act_blank_nxt[w_idx_nxt]) begin
            w_seg_low = w_seg_dec;
            w_dp_low  = ~w_act_dp_nxt[w_idx_nxt];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= SHOW;
         r_idx        <= '0;
         r_cnt        <= '0;
         r_act_val    <= '0;
         r_act_dp     <= '0;
         r_act_blank  <= '1;
         r_pend_val   <= '0;
         r_pend_dp    <= '0;
         r_pend_blank <= '1;
         r_ready      <= 1'b1;
         r_an         <= AN_OFF;
         r_seg        <= SEG_OFF_PHY;
         r_dp         <= DP_OFF_PHY;
         r_tick       <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_idx        <= w_idx_nxt;
         r_cnt        <= w_cnt_nxt;
         r_act_val    <= w_act_val_nxt;
         r_act_dp     <= w_act_dp_nxt;
         r_act_blank  <= w_act_blank_nxt;
         r_pend_val   <= w_pend_val_nxt;
         r_pend_dp    <= w_pend_dp_nxt;
         r_pend_blank <= w_pend_blank_nxt;
         r_ready      <= w_ready_nxt;
         r_an         <= (AN_ACTIVE_LOW != 0)  ? w_an_low  : ~w_an_low;
         r_seg        <= (SEG_ACTIVE_LOW != 0) ? w_seg_low : ~w_seg_low;
         r_dp         <= (SEG_ACTIVE_LOW != 0) ? w_dp_low  : ~w_dp_low;
         r_tick       <= w_boundary;
      end
   end

   assign load_ready = r_ready;
   assign an         = r_an;
   assign seg        = r_seg;
   assign dp         = r_dp;
   assign frame_tick = r_tick;

endmodule
